counter_param: RTL and testbench

Parametrised up/down event counter, successor to the fixed 6-bit enable counter used across the password-checker datapath (attempt counting, character-index tracking, lockout timing). Adds configurable width and modulus, direction control, parallel load, wrap or saturate mode, an enable prescaler, a terminal-count pulse and a sticky overflow flag. Instantiated wherever the checker needs a bounded count with boundary detection.

---
 rtl/counter_pkg.sv | 10 +
 rtl/en_prescaler.sv | 42 ++++
 rtl/counter_param.sv | 113 +++++++++++
 tb/tb_counter_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the parametrised event counter family.
package counter_pkg;

    localparam int   CNT_WRAP = 0;
    localparam int   CNT_SAT  = 1;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

endpackage

// File: rtl/en_prescaler.sv
// Enable prescaler: emits one step per PRESCALE qualified en cycles.
module en_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step
);

    generate
        if (PRESCALE <= 1) begin : g_pass
            assign step = en & ~restart;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] psc_r;

            assign step = en & ~restart & (psc_r == LAST);

            // Phase counter advances only on en cycles; restart discards the phase.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    psc_r <= {PW{1'b0}};
                end else if (restart) begin
                    psc_r <= {PW{1'b0}};
                end else if (en) begin
                    if (psc_r == LAST) begin
                        psc_r <= {PW{1'b0}};
                    end else begin
                        psc_r <= psc_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    psc_r <= psc_r;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/counter_param.sv
// Parametrised up/down counter with load, wrap/saturate, prescaler,
// terminal-count pulse and sticky overflow.
module counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 6,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = CNT_WRAP,
    parameter int              PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             overflow,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             ovf_r;
    logic             step_s;
    logic             restart_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] next_s;
    logic             bound_s;

    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
        if ({1'b0, v} > MAX_EXT) begin
            return MAX_W;
        end else begin
            return v;
        end
    endfunction

    assign restart_s = clear | load;

    en_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .restart (restart_s),
        .step    (step_s)
    );

    // Next count and boundary detection; carry/borrow of the widened sum mark the edges.
    always_comb begin
        sum_s   = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
        diff_s  = {1'b0, cnt_r} - {{WIDTH{1'b0}}, 1'b1};
        next_s  = cnt_r;
        bound_s = 1'b0;
        if (up == CNT_UP) begin
            if (sum_s > MAX_EXT) begin
                bound_s = 1'b1;
                next_s  = (SATURATE == CNT_SAT) ? MAX_W : ZERO_W;
            end else begin
                next_s  = sum_s[WIDTH-1:0];
            end
        end else begin
            if (diff_s[WIDTH]) begin
                bound_s = 1'b1;
                next_s  = (SATURATE == CNT_SAT) ? ZERO_W : MAX_W;
            end else begin
                next_s  = diff_s[WIDTH-1:0];
            end
        end
    end

    // Count register and boundary flags: clear > load > step > hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= ZERO_W;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (clear) begin
            cnt_r <= ZERO_W;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (load) begin
            cnt_r <= clamp_to_max(load_val);
            tc_r  <= 1'b0;
            ovf_r <= ovf_r;
        end else if (step_s) begin
            cnt_r <= next_s;
            tc_r  <= bound_s;
            ovf_r <= ovf_r | bound_s;
        end else begin
            cnt_r <= cnt_r;
            tc_r  <= 1'b0;
            ovf_r <= ovf_r;
        end
    end

    assign out      = cnt_r;
    assign tc       = tc_r;
    assign overflow = ovf_r;
    assign at_max   = (cnt_r == MAX_W);
    assign at_zero  = (cnt_r == ZERO_W);

endmodule

// File: tb/tb_counter_param.sv
// Random and directed checks of four counter_param configurations against
// an arithmetic reference model.
module tb_counter_param;

    localparam int N = 4;
    localparam int P_MAX [N] = '{9, 40, 63, 63};
    localparam int P_SAT [N] = '{0, 1, 0, 0};
    localparam int P_PRE [N] = '{1, 1, 3, 1};

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_val = 6'd0;

    logic [5:0] d_out  [N];
    logic       d_tc   [N];
    logic       d_ov   [N];
    logic       d_max  [N];
    logic       d_zero [N];

    int m_cnt [N];
    int m_psc [N];
    bit m_tc  [N];
    bit m_ov  [N];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        counter_param #(
            .WIDTH    (6),
            .MAX_VAL  (P_MAX[g]),
            .SATURATE (P_SAT[g]),
            .PRESCALE (P_PRE[g])
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .en       (en),
            .up       (up),
            .clear    (clear),
            .load     (load),
            .load_val (load_val),
            .out      (d_out[g]),
            .tc       (d_tc[g]),
            .overflow (d_ov[g]),
            .at_max   (d_max[g]),
            .at_zero  (d_zero[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_psc[i] = 0;
            m_tc[i]  = 1'b0;
            m_ov[i]  = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            if (clear) begin
                m_cnt[i] = 0; m_psc[i] = 0; m_tc[i] = 1'b0; m_ov[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) > P_MAX[i]) ? P_MAX[i] : int'(load_val);
                m_psc[i] = 0; m_tc[i] = 1'b0;
            end else if (en && m_psc[i] == P_PRE[i] - 1) begin
                m_psc[i] = 0;
                m_tc[i]  = 1'b0;
                if (up) begin
                    if (m_cnt[i] == P_MAX[i]) begin
                        m_tc[i] = 1'b1; m_ov[i] = 1'b1;
                        if (P_SAT[i] == 0) m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    if (m_cnt[i] == 0) begin
                        m_tc[i] = 1'b1; m_ov[i] = 1'b1;
                        if (P_SAT[i] == 0) m_cnt[i] = P_MAX[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end else begin
                if (en) m_psc[i] = m_psc[i] + 1;
                m_tc[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("out%0d", i),  d_out[i],  m_cnt[i]);
            check_eq($sformatf("tc%0d", i),   d_tc[i],   m_tc[i]);
            check_eq($sformatf("ovf%0d", i),  d_ov[i],   m_ov[i]);
            check_eq($sformatf("max%0d", i),  d_max[i],  m_cnt[i] == P_MAX[i]);
            check_eq($sformatf("zero%0d", i), d_zero[i], m_cnt[i] == 0);
        end
    endtask

    task automatic step_cycle();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    // Called #1 after an edge: reset asserted mid-cycle, checked before the next edge.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("rst_out%0d", i),  d_out[i],  32'd0);
            check_eq($sformatf("rst_tc%0d", i),   d_tc[i],   32'd0);
            check_eq($sformatf("rst_ovf%0d", i),  d_ov[i],   32'd0);
            check_eq($sformatf("rst_zero%0d", i), d_zero[i], 32'd1);
        end
        model_reset();
        #2 reset = 1'b1;
    endtask

    initial begin
        int sd [4];
        int r;
        sd = '{1, 0, 0, 0};
        model_reset();
        #11;
        check_all();
        reset = 1'b1;

        // Wrap up on MAX_VAL=9
        clear = 1'b1; step_cycle(); clear = 1'b0;
        up = 1'b1; en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            check_eq("wrap_out", d_out[0], (k < 10) ? k : 0);
            check_eq("wrap_tc",  d_tc[0],  (k == 10) ? 1 : 0);
        end
        en = 1'b0; step_cycle();
        check_eq("wrap_ovf_sticky", d_ov[0], 32'd1);
        check_eq("wrap_tc_drop",    d_tc[0], 32'd0);

        // Saturate down on MAX_VAL=40
        load_val = 6'd2; load = 1'b1; step_cycle(); load = 1'b0;
        up = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step_cycle();
            check_eq("sat_out", d_out[1], sd[k]);
            check_eq("sat_tc",  d_tc[1],  (k >= 2) ? 1 : 0);
        end
        check_eq("sat_zero", d_zero[1], 32'd1);
        en = 1'b0;

        // Prescaler of 3, en alternating
        clear = 1'b1; step_cycle(); clear = 1'b0; up = 1'b1;
        for (int k = 0; k < 18; k++) begin
            en = (k % 2 == 0);
            step_cycle();
        end
        check_eq("psc_out", d_out[2], 32'd3);
        en = 1'b0;

        // Priority clear > load > step, then load clamp
        clear = 1'b1; load = 1'b1; load_val = 6'd5; en = 1'b1; step_cycle();
        check_eq("prio_out", d_out[1], 32'd0);
        clear = 1'b0; load_val = 6'd63; step_cycle();
        check_eq("clamp_out", d_out[1], 32'd40);
        check_eq("clamp_max", d_max[1], 32'd1);
        load = 1'b0; en = 1'b0;

        // Direction switch on full-range wrap counter
        clear = 1'b1; step_cycle(); clear = 1'b0;
        en = 1'b1; up = 1'b0; step_cycle();
        check_eq("dir_down_out", d_out[3], 32'd63);
        check_eq("dir_down_tc",  d_tc[3],  32'd1);
        up = 1'b1; step_cycle();
        check_eq("dir_up_out", d_out[3], 32'd0);
        check_eq("dir_up_tc",  d_tc[3],  32'd1);
        en = 1'b0; clear = 1'b1; step_cycle(); clear = 1'b0;
        check_eq("dir_clr_ovf", d_ov[3], 32'd0);

        // Reset mid-count at 17
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 17; k++) step_cycle();
        check_eq("mid_out", d_out[3], 32'd17);
        async_reset();

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            r        = $urandom_range(0, 99);
            clear    = (r < 2);
            load     = (r >= 2 && r < 7);
            load_val = 6'($urandom);
            en       = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) up = ~up;
            step_cycle();
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
